pypkt_sched: RTL and testbench
==============================

Name: pypkt_sched

Overview:
- Payload-path sequencer placed directly in front of the payload bit processor (pybitp).
- Accepts one TX or RX payload job: packet type plus payload byte count. Decodes the type into coding flags and bit length, then issues the single-cycle payload start strobe.
- Gates the 1 µs bit-valid strobe to the datapath and watches the datapath period flags to detect completion.
- Reports done or error (unsupported type, watchdog timeout, abort) to the link controller.

Parameters:
- TIMEOUT_US, 3200, watchdog limit in p_1us ticks measured from py_st_p.
- WD_W, 12, watchdog counter width; must satisfy 2^WD_W > TIMEOUT_US.

Ports:
- clk_6M  in  1  system clock, 6 MHz.
- rst  in  1  synchronous reset, active-high.
- p_1us  in  1  1 µs tick, one clk_6M cycle wide.
- req  in  1  job request pulse; sampled only in IDLE.
- req_rx  in  1  1 = receive/decode job, 0 = transmit/encode job.
- req_pk_type  in  4  BR packet type code.
- req_lenbyte  in  10  user payload bytes, excluding payload header.
- abort  in  1  cancel current job.
- py_period  in  1  datapath payload-active flag.
- dec_py_period  in  1  datapath decode-active flag.
- busy  out  1  job in progress (state != IDLE).
- py_st_p  out  1  payload start pulse to datapath.
- pk_type  out  4  latched packet type.
- pylenbit  out  13  (header bytes + clamped length) × 8.
- crcencode, fec31encode, fec32encode  out  1 each  latched coding flags.
- pk_encode  out  1  equals ~req_rx, latched.
- existpyheader  out  1  packet type carries a payload header.
- BRss  out  1  1 = 1-byte payload header; 0 = 2-byte header.
- py_datvalid_p  out  1  p_1us gated to START/RUN.
- done_p  out  1  one-cycle completion pulse.
- err_p  out  1  one-cycle error pulse.
- err_code  out  2  0 none, 1 unsupported type, 2 timeout, 3 abort.
- len_clamped  out  1  requested length exceeded the type maximum.

Behaviour:
- Reset (rst high at a clk_6M edge): state IDLE, all outputs 0, err_code 0.
- States: IDLE, CFG, START, RUN, FIN.
- IDLE → CFG when req=1. The cycle before CFG latches req_rx, req_pk_type and req_lenbyte.
- CFG (1 cycle): table lookup. Entries are {hdr bytes, max bytes, crc, fec31, fec32}:
  - 0x2 FHS {0,18,1,0,1}; user length is ignored and forced to 18.
  - 0x3 DM1 {1,17,1,0,1}; 0x4 DH1 {1,27,1,0,0}.
  - 0x5 HV1 {0,10,0,1,0}; 0x6 HV2 {0,20,0,0,1}; 0x7 HV3 {0,30,0,0,0}.
  - 0x9 AUX1 {1,29,0,0,0}.
  - 0xA DM3 {2,121,1,0,1}; 0xB DH3 {2,183,1,0,0}.
  - 0xE DM5 {2,224,1,0,1}; 0xF DH5 {2,339,1,0,0}.
  - 0x0 and 0x1 have length 0.
- Length rules:
  - HV types use the fixed length.
  - Otherwise len = min(req_lenbyte, max); len_clamped = (req_lenbyte > max).
  - existpyheader = (hdr != 0); BRss = (hdr <= 1).
- CFG transitions:
  - Other type codes (0x8, 0xC, 0xD) → FIN with err_code 1.
  - pylenbit == 0 → FIN with success (no py_st_p).
  - Otherwise → START.
- START: waits for p_1us. On that cycle py_st_p=1 for exactly one cycle, the watchdog clears, and the state goes to RUN.
- RUN:
  - `seen` sets when (py_period | dec_py_period) = 1.
  - Completion when seen = 1 and both flags are 0 → FIN with success.
  - Watchdog increments on each p_1us; reaching TIMEOUT_US → FIN with err_code 2.
- abort=1 in CFG/START/RUN → FIN with err_code 3 on the next edge. Priority: abort > timeout > completion.
- FIN (1 cycle):
  - Success: done_p=1, err_code=0.
  - Error: err_p=1 and err_code holds its value until the next accepted req.
  - Then → IDLE.
- Config outputs (pk_type, pylenbit, flags) hold until the next CFG.
- req while busy is ignored; there is no queueing.
- py_datvalid_p = p_1us & (state==START | state==RUN).

Test Plan:
- TX DH1, req_lenbyte=10 → pylenbit=88, crcencode=1, fec31=fec32=0, BRss=1, existpyheader=1. One py_st_p on a p_1us cycle. Drop py_period after 104 ticks → done_p one cycle later, err_code 0.
- TX DM1, req_lenbyte=40 → len_clamped=1, pylenbit=144, fec32encode=1.
- RX DH5, req_lenbyte=339, req_rx=1 → pk_encode=0, BRss=0, pylenbit=2728. Hold dec_py_period past py_period fall → done_p only after dec_py_period falls.
- Type 0x0 → done_p 2 cycles after req, py_st_p never asserted. Type 0xC → err_p with err_code=1.
- DH1 job with py_period stuck at 1 → err_p with err_code=2 exactly 3200 p_1us ticks after py_st_p.
- Abort pulse in RUN, simultaneous with the watchdog limit → err_code=3. A req during RUN is ignored. rst in RUN → IDLE with all outputs 0 on the next edge.

Source files
------------

// File: rtl/pypkt_sched.sv
// pypkt_sched: payload-path sequencer in front of the payload bit processor.
// Accepts one TX/RX payload job (packet type + byte count), decodes the
// type into coding flags and payload bit length, issues the payload start
// strobe on a 1 us tick, gates the bit-valid strobe while the job runs and
// watches the datapath period flags for completion. Reports done or error
// (unsupported type, watchdog timeout, abort).
//
// Ports:
//   clk_6M, rst            6 MHz clock, synchronous active-high reset
//   p_1us                  1 us tick, one clk_6M cycle wide
//   req, req_rx,
//   req_pk_type,
//   req_lenbyte            job request (sampled only when idle)
//   abort                  cancel the current job
//   py_period,
//   dec_py_period          datapath payload / decode activity flags
//   busy                   job in progress
//   py_st_p                payload start pulse to the datapath
//   pk_type, pylenbit,
//   crcencode, fec31encode,
//   fec32encode, pk_encode,
//   existpyheader, BRss,
//   len_clamped            latched job configuration
//   py_datvalid_p          p_1us gated to START/RUN
//   done_p, err_p,
//   err_code               completion / error report (0 none, 1 type,
//                          2 timeout, 3 abort)
module pypkt_sched #(
  parameter int unsigned TIMEOUT_US = 3200,
  parameter int unsigned WD_W       = 12
) (
  input  logic        clk_6M,
  input  logic        rst,
  input  logic        p_1us,
  input  logic        req,
  input  logic        req_rx,
  input  logic [3:0]  req_pk_type,
  input  logic [9:0]  req_lenbyte,
  input  logic        abort,
  input  logic        py_period,
  input  logic        dec_py_period,
  output logic        busy,
  output logic        py_st_p,
  output logic [3:0]  pk_type,
  output logic [12:0] pylenbit,
  output logic        crcencode,
  output logic        fec31encode,
  output logic        fec32encode,
  output logic        pk_encode,
  output logic        existpyheader,
  output logic        BRss,
  output logic        py_datvalid_p,
  output logic        done_p,
  output logic        err_p,
  output logic [1:0]  err_code,
  output logic        len_clamped
);

  typedef enum logic [2:0] {IDLE, CFG, START, RUN, FIN} state_t;

  localparam logic [1:0] EC_NONE  = 2'd0;
  localparam logic [1:0] EC_TYPE  = 2'd1;
  localparam logic [1:0] EC_TMO   = 2'd2;
  localparam logic [1:0] EC_ABORT = 2'd3;

  // Watchdog fires on the tick that would bring the count to TIMEOUT_US.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_US - 1);

  state_t state, state_nx;
  logic [1:0] fin_code;

  logic        job_rx;
  logic [3:0]  job_type;
  logic [9:0]  job_len;
  logic [WD_W-1:0] wd_cnt;
  logic        seen;

  logic        cfg_ok, cfg_fixed, cfg_crc, cfg_f31, cfg_f32;
  logic [1:0]  cfg_hdr;
  logic [9:0]  cfg_max;
  logic [9:0]  cfg_len;
  logic        cfg_clamp;
  logic [12:0] cfg_bits;

  logic wd_hit, py_done;

  // Packet type table: header bytes, max payload bytes, coding flags.
  // Fixed-length types (NULL/POLL, FHS, HV) ignore the requested length.
  always_comb begin
    cfg_ok    = 1'b1;
    cfg_fixed = 1'b0;
    cfg_hdr   = 2'd0;
    cfg_max   = 10'd0;
    cfg_crc   = 1'b0;
    cfg_f31   = 1'b0;
    cfg_f32   = 1'b0;
    case (job_type)
      4'h0, 4'h1: cfg_fixed = 1'b1;
      4'h2: begin cfg_fixed = 1'b1; cfg_max = 10'd18; cfg_crc = 1'b1; cfg_f32 = 1'b1; end
      4'h3: begin cfg_hdr = 2'd1; cfg_max = 10'd17; cfg_crc = 1'b1; cfg_f32 = 1'b1; end
      4'h4: begin cfg_hdr = 2'd1; cfg_max = 10'd27; cfg_crc = 1'b1; end
      4'h5: begin cfg_fixed = 1'b1; cfg_max = 10'd10; cfg_f31 = 1'b1; end
      4'h6: begin cfg_fixed = 1'b1; cfg_max = 10'd20; cfg_f32 = 1'b1; end
      4'h7: begin cfg_fixed = 1'b1; cfg_max = 10'd30; end
      4'h9: begin cfg_hdr = 2'd1; cfg_max = 10'd29; end
      4'hA: begin cfg_hdr = 2'd2; cfg_max = 10'd121; cfg_crc = 1'b1; cfg_f32 = 1'b1; end
      4'hB: begin cfg_hdr = 2'd2; cfg_max = 10'd183; cfg_crc = 1'b1; end
      4'hE: begin cfg_hdr = 2'd2; cfg_max = 10'd224; cfg_crc = 1'b1; cfg_f32 = 1'b1; end
      4'hF: begin cfg_hdr = 2'd2; cfg_max = 10'd339; cfg_crc = 1'b1; end
      default: begin cfg_ok = 1'b0; cfg_fixed = 1'b1; end
    endcase
  end

  always_comb begin
    cfg_clamp = !cfg_fixed && (job_len > cfg_max);
    cfg_len   = (cfg_fixed || cfg_clamp) ? cfg_max : job_len;
    cfg_bits  = {cfg_len + {8'd0, cfg_hdr}, 3'b000};
  end

  assign wd_hit  = p_1us && (wd_cnt == WD_LAST);
  assign py_done = seen && !py_period && !dec_py_period;

  always_comb begin
    state_nx = state;
    fin_code = EC_NONE;
    case (state)
      IDLE: if (req) state_nx = CFG;
      CFG: begin
        if (abort) begin
          state_nx = FIN;
          fin_code = EC_ABORT;
        end else if (!cfg_ok) begin
          state_nx = FIN;
          fin_code = EC_TYPE;
        end else if (cfg_bits == '0) begin
          state_nx = FIN;
        end else begin
          state_nx = START;
        end
      end
      START: begin
        if (abort) begin
          state_nx = FIN;
          fin_code = EC_ABORT;
        end else if (p_1us) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = FIN;
          fin_code = EC_ABORT;
        end else if (wd_hit) begin
          state_nx = FIN;
          fin_code = EC_TMO;
        end else if (py_done) begin
          state_nx = FIN;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy          = (state != IDLE);
  assign py_st_p       = (state == START) && p_1us;
  assign py_datvalid_p = p_1us && ((state == START) || (state == RUN));

  always_ff @(posedge clk_6M) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      job_rx        <= 1'b0;
      job_type      <= '0;
      job_len       <= '0;
      wd_cnt        <= '0;
      seen          <= 1'b0;
      pk_type       <= '0;
      pylenbit      <= '0;
      crcencode     <= 1'b0;
      fec31encode   <= 1'b0;
      fec32encode   <= 1'b0;
      pk_encode     <= 1'b0;
      existpyheader <= 1'b0;
      BRss          <= 1'b0;
      len_clamped   <= 1'b0;
      done_p        <= 1'b0;
      err_p         <= 1'b0;
      err_code      <= EC_NONE;
    end else begin
      done_p <= 1'b0;
      err_p  <= 1'b0;

      if (state == IDLE && req) begin
        job_rx   <= req_rx;
        job_type <= req_pk_type;
        job_len  <= req_lenbyte;
        err_code <= EC_NONE;
      end

      if (state == CFG) begin
        pk_type       <= job_type;
        pylenbit      <= cfg_bits;
        crcencode     <= cfg_crc;
        fec31encode   <= cfg_f31;
        fec32encode   <= cfg_f32;
        pk_encode     <= ~job_rx;
        existpyheader <= (cfg_hdr != 2'd0);
        BRss          <= (cfg_hdr <= 2'd1);
        len_clamped   <= cfg_clamp;
      end

      if (state == START && p_1us) begin
        wd_cnt <= '0;
        seen   <= 1'b0;
      end else if (state == RUN) begin
        if (p_1us) wd_cnt <= wd_cnt + 1'b1;
        if (py_period || dec_py_period) seen <= 1'b1;
      end

      // Report is registered on entry to FIN so it is visible for exactly
      // the FIN cycle; err_code then holds until the next accepted req.
      if (state != FIN && state_nx == FIN) begin
        if (fin_code == EC_NONE) begin
          done_p <= 1'b1;
        end else begin
          err_p    <= 1'b1;
          err_code <= fin_code;
        end
      end
    end
  end

endmodule

// File: tb/tb_pypkt_sched.sv
`timescale 1ns/1ps
module tb_pypkt_sched;

  logic        clk_6M = 1'b0;
  logic        rst;
  logic        p_1us;
  logic        req;
  logic        req_rx;
  logic [3:0]  req_pk_type;
  logic [9:0]  req_lenbyte;
  logic        abort;
  logic        py_period;
  logic        dec_py_period;
  logic        busy;
  logic        py_st_p;
  logic [3:0]  pk_type;
  logic [12:0] pylenbit;
  logic        crcencode;
  logic        fec31encode;
  logic        fec32encode;
  logic        pk_encode;
  logic        existpyheader;
  logic        BRss;
  logic        py_datvalid_p;
  logic        done_p;
  logic        err_p;
  logic [1:0]  err_code;
  logic        len_clamped;

  pypkt_sched #(.TIMEOUT_US(3200), .WD_W(12)) dut (
    .clk_6M(clk_6M), .rst(rst), .p_1us(p_1us), .req(req), .req_rx(req_rx),
    .req_pk_type(req_pk_type), .req_lenbyte(req_lenbyte), .abort(abort),
    .py_period(py_period), .dec_py_period(dec_py_period), .busy(busy),
    .py_st_p(py_st_p), .pk_type(pk_type), .pylenbit(pylenbit),
    .crcencode(crcencode), .fec31encode(fec31encode), .fec32encode(fec32encode),
    .pk_encode(pk_encode), .existpyheader(existpyheader), .BRss(BRss),
    .py_datvalid_p(py_datvalid_p), .done_p(done_p), .err_p(err_p),
    .err_code(err_code), .len_clamped(len_clamped)
  );

  initial forever #83 clk_6M = ~clk_6M;

  // 1 us tick: one cycle high out of every six.
  initial begin
    p_1us = 1'b0;
    forever begin
      repeat (5) @(posedge clk_6M);
      #1 p_1us = 1'b1;
      @(posedge clk_6M);
      #1 p_1us = 1'b0;
    end
  end

  typedef struct {
    logic        rx;
    logic [3:0]  ty;
    logic [9:0]  len;
    int          hold;
    int          dec_extra;
    logic        done;
    logic [1:0]  code;
    logic        chk;
    logic [12:0] bits;
    logic        crc, f31, f32, hdr, brss, clamp;
    int          st;
    int          reqlat;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t sb_q[$];
  vec_t tbl[17];
  vec_t e;

  function automatic vec_t mk(input int rx, input int ty, input int len,
                              input int hold, input int dx, input int done,
                              input int code, input int chk, input int bits,
                              input int crc, input int f31, input int f32,
                              input int hdr, input int brss, input int clamp,
                              input int st, input int rl);
    vec_t v;
    v.rx = rx[0]; v.ty = ty[3:0]; v.len = len[9:0];
    v.hold = hold; v.dec_extra = dx;
    v.done = done[0]; v.code = code[1:0]; v.chk = chk[0];
    v.bits = bits[12:0];
    v.crc = crc[0]; v.f31 = f31[0]; v.f32 = f32[0];
    v.hdr = hdr[0]; v.brss = brss[0]; v.clamp = clamp[0];
    v.st = st; v.reqlat = rl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: each job end pops the expectation pushed when it was issued.
  always @(negedge clk_6M) begin
    if (py_st_p) check("st_on_tick", 32'(p_1us), 32'd1);
    if (!busy && p_1us) check("dv_idle", 32'(py_datvalid_p), 32'd0);
    if (done_p || err_p) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_end", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("ty%0h_done", e.ty), 32'(done_p), 32'(e.done));
        check($sformatf("ty%0h_err", e.ty), 32'(err_p), 32'(!e.done));
        check($sformatf("ty%0h_code", e.ty), 32'(err_code), 32'(e.code));
        if (e.chk) begin
          check($sformatf("ty%0h_pk_type", e.ty), 32'(pk_type), 32'(e.ty));
          check($sformatf("ty%0h_bits", e.ty), 32'(pylenbit), 32'(e.bits));
          check($sformatf("ty%0h_crc", e.ty), 32'(crcencode), 32'(e.crc));
          check($sformatf("ty%0h_f31", e.ty), 32'(fec31encode), 32'(e.f31));
          check($sformatf("ty%0h_f32", e.ty), 32'(fec32encode), 32'(e.f32));
          check($sformatf("ty%0h_hdr", e.ty), 32'(existpyheader), 32'(e.hdr));
          check($sformatf("ty%0h_brss", e.ty), 32'(BRss), 32'(e.brss));
          check($sformatf("ty%0h_clamp", e.ty), 32'(len_clamped), 32'(e.clamp));
          check($sformatf("ty%0h_encode", e.ty), 32'(pk_encode), 32'(!e.rx));
        end
      end
    end
  end

  // Issue one job, model the datapath flags, optionally inject abort or a
  // stray req at a given tick count after py_st_p.
  task automatic run_job(input vec_t v, input int abort_tick, input int req_tick,
                         output int n_st, output int ticks, output int drop_lat,
                         output int req_lat, output bit early);
    int cyc, drop_cyc;
    bit started, dropped, ended;
    n_st = 0; ticks = 0; drop_lat = -1; req_lat = -1; early = 0;
    cyc = 0; drop_cyc = 0; started = 0; dropped = 0; ended = 0;
    @(negedge clk_6M);
    req_rx = v.rx; req_pk_type = v.ty; req_lenbyte = v.len; req = 1'b1;
    sb_q.push_back(v);
    while (cyc < 30000 && !ended) begin
      @(negedge clk_6M);
      cyc++;
      req = 1'b0;
      abort = 1'b0;
      if (done_p || err_p) begin
        ended = 1;
        req_lat = cyc;
        early = py_period | dec_py_period;
        if (dropped) drop_lat = cyc - drop_cyc;
      end else if (py_st_p) begin
        n_st++;
        started = 1;
        py_period = 1'b1;
        dec_py_period = v.rx;
      end else if (started && p_1us) begin
        ticks++;
        if (ticks == v.hold) py_period = 1'b0;
        if (ticks == v.hold + v.dec_extra) dec_py_period = 1'b0;
        if (!dropped && !py_period && !dec_py_period) begin
          dropped = 1;
          drop_cyc = cyc;
        end
        if (ticks == abort_tick) abort = 1'b1;
        if (ticks == req_tick) begin
          req_pk_type = 4'hC; req_lenbyte = 10'd0; req = 1'b1;
        end
      end
    end
    if (!ended) begin
      n_tests++;
      n_fail++;
      $display("FAIL job_wait ty%0h: got no done_p/err_p expected one within 30000 cycles", v.ty);
      if (sb_q.size() > 0) void'(sb_q.pop_back());
    end
    py_period = 1'b0; dec_py_period = 1'b0; abort = 1'b0; req = 1'b0;
  endtask

  int  n_st, ticks, drop_lat, req_lat;
  bit  early;
  vec_t v;
  logic [31:0] all_out;
  bit  found;

  initial begin
    //            rx ty    len  hold dx dn cd ck bits crc f31 f32 hdr brs clp st rl
    tbl[0]  = mk(0, 4'h4,  10, 104, 0, 1, 0, 1,   88, 1, 0, 0, 1, 1, 0, 1, 0);
    tbl[1]  = mk(0, 4'h3,  40,  20, 0, 1, 0, 1,  144, 1, 0, 1, 1, 1, 1, 1, 0);
    tbl[2]  = mk(1, 4'hF, 339,  50,20, 1, 0, 1, 2728, 1, 0, 0, 1, 0, 0, 1, 0);
    tbl[3]  = mk(0, 4'h5,   5,  10, 0, 1, 0, 1,   80, 0, 1, 0, 0, 1, 0, 1, 0);
    tbl[4]  = mk(0, 4'h6,   7,  10, 0, 1, 0, 1,  160, 0, 0, 1, 0, 1, 0, 1, 0);
    tbl[5]  = mk(0, 4'h7, 100,  10, 0, 1, 0, 1,  240, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[6]  = mk(0, 4'h2,   3,  10, 0, 1, 0, 1,  144, 1, 0, 1, 0, 1, 0, 1, 0);
    tbl[7]  = mk(1, 4'hA, 121,  10, 5, 1, 0, 1,  984, 1, 0, 1, 1, 0, 0, 1, 0);
    tbl[8]  = mk(0, 4'hA, 122,  10, 0, 1, 0, 1,  984, 1, 0, 1, 1, 0, 1, 1, 0);
    tbl[9]  = mk(0, 4'hB,   0,  10, 0, 1, 0, 1,   16, 1, 0, 0, 1, 0, 0, 1, 0);
    tbl[10] = mk(0, 4'h9,  29,  10, 0, 1, 0, 1,  240, 0, 0, 0, 1, 1, 0, 1, 0);
    tbl[11] = mk(0, 4'hE,1023,  10, 0, 1, 0, 1, 1808, 1, 0, 1, 1, 0, 1, 1, 0);
    tbl[12] = mk(0, 4'h0,   0,   0, 0, 1, 0, 1,    0, 0, 0, 0, 0, 1, 0, 0, 2);
    tbl[13] = mk(1, 4'h1,   0,   0, 0, 1, 0, 1,    0, 0, 0, 0, 0, 1, 0, 0, 2);
    tbl[14] = mk(0, 4'hC,   5,   0, 0, 0, 1, 0,    0, 0, 0, 0, 0, 0, 0, 0, 2);
    tbl[15] = mk(0, 4'h8,   5,   0, 0, 0, 1, 0,    0, 0, 0, 0, 0, 0, 0, 0, 2);
    tbl[16] = mk(1, 4'hD,   5,   0, 0, 0, 1, 0,    0, 0, 0, 0, 0, 0, 0, 0, 2);

    rst = 1'b1; req = 1'b0; req_rx = 1'b0; req_pk_type = '0; req_lenbyte = '0;
    abort = 1'b0; py_period = 1'b0; dec_py_period = 1'b0;
    repeat (3) @(negedge clk_6M);
    all_out = 32'({busy, py_st_p, pk_type, pylenbit, crcencode, fec31encode,
                   fec32encode, pk_encode, existpyheader, BRss, py_datvalid_p,
                   done_p, err_p, err_code, len_clamped});
    check("reset_outputs", all_out, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      run_job(tbl[i], -1, -1, n_st, ticks, drop_lat, req_lat, early);
      check($sformatf("row%0d_st_count", i), 32'(n_st), 32'(tbl[i].st));
      if (tbl[i].st == 1) begin
        check($sformatf("row%0d_early_done", i), 32'(early), 32'd0);
        check($sformatf("row%0d_drop_latency", i), 32'(drop_lat), 32'd1);
      end
      if (tbl[i].reqlat != 0)
        check($sformatf("row%0d_req_latency", i), 32'(req_lat), 32'(tbl[i].reqlat));
      @(negedge clk_6M);
      check($sformatf("row%0d_idle_busy", i), 32'(busy), 32'd0);
      check($sformatf("row%0d_code_hold", i), 32'(err_code), 32'(tbl[i].code));
    end

    // Stray req during RUN must be ignored.
    v = mk(0, 4'h3, 5, 30, 0, 1, 0, 1, 48, 1, 0, 1, 1, 1, 0, 1, 0);
    run_job(v, -1, 10, n_st, ticks, drop_lat, req_lat, early);
    check("req_in_run_st_count", 32'(n_st), 32'd1);
    repeat (12) @(negedge clk_6M);
    check("req_in_run_no_extra", 32'(sb_q.size()), 32'd0);
    check("req_in_run_idle", 32'(busy), 32'd0);

    // Watchdog: py_period stuck high.
    v = mk(0, 4'h4, 10, 100000, 0, 0, 2, 1, 88, 1, 0, 0, 1, 1, 0, 1, 0);
    run_job(v, -1, -1, n_st, ticks, drop_lat, req_lat, early);
    check("timeout_ticks", 32'(ticks), 32'd3200);
    repeat (4) @(negedge clk_6M);
    check("timeout_code_hold", 32'(err_code), 32'd2);

    // Abort coinciding with the watchdog limit: abort wins.
    v = mk(0, 4'h4, 10, 100000, 0, 0, 3, 1, 88, 1, 0, 0, 1, 1, 0, 1, 0);
    run_job(v, 3200, -1, n_st, ticks, drop_lat, req_lat, early);
    check("abort_ticks", 32'(ticks), 32'd3200);
    repeat (4) @(negedge clk_6M);
    check("abort_code_hold", 32'(err_code), 32'd3);

    // Reset in RUN.
    @(negedge clk_6M);
    req_rx = 1'b0; req_pk_type = 4'h4; req_lenbyte = 10'd10; req = 1'b1;
    @(negedge clk_6M);
    req = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (py_st_p) found = 1;
      else @(negedge clk_6M);
    end
    check("rst_run_started", 32'(found), 32'd1);
    py_period = 1'b1;
    repeat (5) @(negedge clk_6M);
    check("rst_run_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk_6M);
    all_out = 32'({busy, py_st_p, pk_type, pylenbit, crcencode, fec31encode,
                   fec32encode, pk_encode, existpyheader, BRss, py_datvalid_p,
                   done_p, err_p, err_code, len_clamped});
    check("rst_run_outputs", all_out, 32'd0);
    rst = 1'b0;
    py_period = 1'b0;
    repeat (10) @(negedge clk_6M);
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
